// File: rtl/mem_access_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Each transaction takes three cycles: grant, issue and capture.
module mem_access_arbiter #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 16,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int ROM_SIZE         = 128
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        f_req,
  input  logic [ADDR_BITS-1:0]        f_pc,
  output logic                        f_ready,
  output logic                        f_valid,
  output logic [INSTRUCTION_SIZE-1:0] f_inst,
  input  logic                        d_req,
  input  logic                        d_we,
  input  logic [ADDR_BITS-1:0]        d_addr,
  input  logic [DATA_BITS-1:0]        d_wdata,
  output logic                        d_ready,
  output logic                        d_valid,
  output logic [INSTRUCTION_SIZE-1:0] d_rdata,
  output logic                        d_err,
  output logic [ADDR_BITS-1:0]        m_pc,
  output logic [ADDR_BITS-1:0]        m_addr,
  output logic [DATA_BITS-1:0]        m_wdat,
  output logic                        m_we,
  output logic                        m_cs,
  output logic                        m_mm_select,
  input  logic [INSTRUCTION_SIZE-1:0] m_inst,
  input  logic [INSTRUCTION_SIZE-1:0] m_dat,
  input  logic                        m_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  starve_q, starve_d;
  logic                        fetch_q, fetch_d;
  logic                        store_q, store_d;
  logic [ADDR_BITS-1:0]        m_pc_q, m_pc_d;
  logic [ADDR_BITS-1:0]        m_addr_q, m_addr_d;
  logic [DATA_BITS-1:0]        m_wdat_q, m_wdat_d;
  logic                        m_we_q, m_we_d;
  logic                        m_cs_q, m_cs_d;
  logic                        m_mm_q, m_mm_d;
  logic                        f_valid_q, f_valid_d;
  logic [INSTRUCTION_SIZE-1:0] f_inst_q, f_inst_d;
  logic                        d_valid_q, d_valid_d;
  logic [INSTRUCTION_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                        d_err_q, d_err_d;
  logic                        grant_f, grant_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      fetch_q   <= 1'b0;
      store_q   <= 1'b0;
      m_pc_q    <= '0;
      m_addr_q  <= '0;
      m_wdat_q  <= '0;
      m_we_q    <= 1'b0;
      m_cs_q    <= 1'b0;
      m_mm_q    <= 1'b0;
      f_valid_q <= 1'b0;
      f_inst_q  <= '0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      fetch_q   <= fetch_d;
      store_q   <= store_d;
      m_pc_q    <= m_pc_d;
      m_addr_q  <= m_addr_d;
      m_wdat_q  <= m_wdat_d;
      m_we_q    <= m_we_d;
      m_cs_q    <= m_cs_d;
      m_mm_q    <= m_mm_d;
      f_valid_q <= f_valid_d;
      f_inst_q  <= f_inst_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    fetch_d   = fetch_q;
    store_d   = store_q;
    m_pc_d    = m_pc_q;
    m_addr_d  = m_addr_q;
    m_wdat_d  = m_wdat_q;
    m_we_d    = m_we_q;
    m_cs_d    = m_cs_q;
    m_mm_d    = m_mm_q;
    f_valid_d = 1'b0;
    f_inst_d  = f_inst_q;
    d_valid_d = 1'b0;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins ties until fetch has lost twice in a row.
        grant_f = f_req && (!d_req || starve_q == 2'd2);
        grant_d = d_req && !grant_f;
        if (grant_f) begin
          state_d  = ISSUE;
          starve_d = 2'd0;
          fetch_d  = 1'b1;
          store_d  = 1'b0;
          m_cs_d   = 1'b1;
          m_we_d   = 1'b0;
          m_mm_d   = 1'b0;
          m_pc_d   = f_pc;
        end else if (grant_d) begin
          state_d  = ISSUE;
          if (f_req && starve_q != 2'd2) begin
            starve_d = starve_q + 2'd1;
          end
          fetch_d  = 1'b0;
          store_d  = d_we;
          m_cs_d   = 1'b0;
          m_we_d   = d_we;
          m_mm_d   = !d_we;
          m_addr_d = d_addr;
          if (d_we) begin
            m_wdat_d = d_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
        m_cs_d  = 1'b0;
        m_we_d  = 1'b0;
        m_mm_d  = 1'b0;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (fetch_q) begin
          f_valid_d = 1'b1;
          f_inst_d  = m_inst;
        end else begin
          d_valid_d = 1'b1;
          if (store_q) begin
            d_err_d = m_error;
          end else begin
            d_err_d   = 1'b0;
            d_rdata_d = m_dat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign f_ready     = grant_f && !RESET;
  assign d_ready     = grant_d && !RESET;
  assign f_valid     = f_valid_q;
  assign f_inst      = f_inst_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign m_pc        = m_pc_q;
  assign m_addr      = m_addr_q;
  assign m_wdat      = m_wdat_q;
  assign m_we        = m_we_q;
  assign m_cs        = m_cs_q;
  assign m_mm_select = m_mm_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural memory
// and a transaction-level reference model.
module tb_mem_access_arbiter;
  localparam int ROM = 128;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        f_req, d_req, d_we;
  logic [7:0]  f_pc, d_addr;
  logic [15:0] d_wdata;
  logic        f_ready, f_valid, d_ready, d_valid, d_err;
  logic [15:0] f_inst, d_rdata;
  logic [7:0]  m_pc, m_addr;
  logic [15:0] m_wdat;
  logic        m_we, m_cs, m_mm_select;
  logic [15:0] m_inst = '0;
  logic [15:0] m_dat = '0;
  logic        m_error = 1'b0;

  mem_access_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .f_req(f_req), .f_pc(f_pc), .f_ready(f_ready),
    .f_valid(f_valid), .f_inst(f_inst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .m_pc(m_pc), .m_addr(m_addr), .m_wdat(m_wdat),
    .m_we(m_we), .m_cs(m_cs), .m_mm_select(m_mm_select),
    .m_inst(m_inst), .m_dat(m_dat), .m_error(m_error)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: registered outputs, ROM below ROM is write-protected.
  logic [15:0] dev_mem [256];
  always @(posedge CLK) begin
    if (m_cs) begin
      m_inst <= dev_mem[m_pc];
    end else if (m_mm_select && !m_we) begin
      m_dat   <= dev_mem[m_addr];
      m_error <= 1'($urandom);
    end else if (m_we) begin
      if (m_addr >= ROM) dev_mem[m_addr] <= m_wdat;
      m_error <= (m_addr < ROM);
    end
  end

  typedef struct {
    bit          is_f;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] ref_mem [256];
  int          st = 0, busy = 0;
  logic [15:0] last_load = '0, last_f = '0;
  bit          chk_issue = 0, chk_cap = 0;
  bit          c_f, c_we;
  logic [7:0]  c_pc, c_addr;
  logic [15:0] c_wd;
  int          dut_grant;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  // Monitor: pops the oldest predicted response on every valid strobe.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && (f_valid || d_valid)) begin
      chk("one_valid", {31'd0, f_valid && d_valid}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", {31'd0, f_valid}, {31'd0, e.is_f});
        if (f_valid) begin
          chk("f_inst", {16'd0, f_inst}, {16'd0, e.data});
          last_f = e.data;
        end else begin
          chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.data});
          chk("d_err", {31'd0, d_err}, {31'd0, e.err});
          chk("f_inst_hold", {16'd0, f_inst}, {16'd0, last_f});
        end
      end
    end
  end

  task automatic cycle(input bit fr, input bit dr, input bit we,
                       input logic [7:0] pc, input logic [7:0] addr,
                       input logic [15:0] wd);
    bit efr, edr;
    exp_t e;
    @(negedge CLK);
    f_req = fr; d_req = dr; d_we = we;
    f_pc = pc; d_addr = addr; d_wdata = wd;
    #1;
    efr = busy == 0 && fr && (!dr || st == 2);
    edr = busy == 0 && dr && !efr;
    chk("f_ready", {31'd0, f_ready}, {31'd0, efr});
    chk("d_ready", {31'd0, d_ready}, {31'd0, edr});
    dut_grant = f_ready ? 1 : (d_ready ? 2 : 0);
    if (chk_issue) begin
      chk("iss_cs", {31'd0, m_cs}, {31'd0, c_f});
      chk("iss_we", {31'd0, m_we}, {31'd0, !c_f && c_we});
      chk("iss_mm", {31'd0, m_mm_select}, {31'd0, !c_f && !c_we});
      if (c_f) chk("iss_pc", {24'd0, m_pc}, {24'd0, c_pc});
      else chk("iss_addr", {24'd0, m_addr}, {24'd0, c_addr});
      if (!c_f && c_we) chk("iss_wdat", {16'd0, m_wdat}, {16'd0, c_wd});
      chk_issue = 0;
      chk_cap = 1;
    end else if (chk_cap) begin
      chk("cap_ctl", {29'd0, m_cs, m_we, m_mm_select}, 0);
      chk_cap = 0;
    end
    if (efr || edr) begin
      c_f = efr; c_we = we; c_pc = pc; c_addr = addr; c_wd = wd;
      chk_issue = 1;
      busy = 2;
      e.is_f = efr;
      e.err = 0;
      if (efr) begin
        st = 0;
        e.data = ref_mem[pc];
      end else begin
        if (fr && st < 2) st++;
        if (we) begin
          e.err = addr < ROM;
          if (addr >= ROM) ref_mem[addr] = wd;
          e.data = last_load;
        end else begin
          e.data = ref_mem[addr];
          last_load = e.data;
        end
      end
      exp_q.push_back(e);
    end else if (busy > 0) begin
      busy--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 8'h00, 16'h0);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {22'd0, f_ready, f_valid, d_ready, d_valid, d_err,
             m_we, m_cs, m_mm_select, 2'b0}, 0);
    chk({nm, "_bus"}, {f_inst | d_rdata | m_wdat, m_pc | m_addr, 8'd0}, 0);
  endtask

  int order[$];

  initial begin
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = 16'($urandom);
      dev_mem[a] = ref_mem[a];
    end
    ref_mem[5] = 16'hA5A5;    dev_mem[5] = 16'hA5A5;
    ref_mem[8'h90] = 16'h1234; dev_mem[8'h90] = 16'h1234;

    RESET = 1; f_req = 1; d_req = 1; d_we = 0;
    f_pc = 8'h33; d_addr = 8'h44; d_wdata = 16'hFFFF;
    #12;
    chk_zero("reset_outs");
    @(posedge CLK); #2;
    RESET = 0;

    cycle(1, 0, 0, 8'h05, 8'h00, 16'h0);
    idle(3);
    cycle(0, 1, 0, 8'h00, 8'h90, 16'h0);
    idle(3);
    cycle(0, 1, 1, 8'h00, 8'h10, 16'hBEEF);
    idle(3);
    cycle(0, 1, 1, 8'h00, 8'h80, 16'hCAFE);
    idle(3);
    cycle(0, 1, 0, 8'h00, 8'h80, 16'h0);
    idle(3);

    order.delete();
    for (int i = 0; i < 18; i++) begin
      cycle(1, 1, 0, 8'(8'h20 + i), 8'(8'hA0 + i), 16'h0);
      if (dut_grant != 0) order.push_back(dut_grant);
    end
    chk("order_len", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk("grant_order", order[i], (i % 3 == 2) ? 1 : 2);
    idle(3);

    cycle(1, 0, 0, 8'h07, 8'h00, 16'h0);
    @(posedge CLK); #2;
    RESET = 1;
    exp_q.delete();
    busy = 0; st = 0; chk_issue = 0; chk_cap = 0;
    last_load = '0; last_f = '0;
    #1;
    chk_zero("mid_reset");
    repeat (3) @(posedge CLK);
    #2;
    RESET = 0;
    cycle(1, 0, 0, 8'h09, 8'h00, 16'h0);
    idle(3);

    for (int i = 0; i < 600; i++)
      cycle(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 16'($urandom));
    idle(4);
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL set the width of the address and PC buses.
REQ-002 Parameter DATA_BITS, default 16, SHALL set the store-data width.
REQ-003 Parameter INSTRUCTION_SIZE, default 16, SHALL set the width of the instruction and read-data buses.
REQ-004 Parameter ROM_SIZE, default 128, SHALL set the first writable address.
REQ-005 Ports SHALL be:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request.
- f_pc  in  ADDR_BITS  fetch address.
- f_ready  out  1  fetch accepted this cycle when f_req=1.
- f_valid  out  1  one-cycle fetch response strobe.
- f_inst  out  INSTRUCTION_SIZE  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_BITS  data address.
- d_wdata  in  DATA_BITS  store data.
- d_ready  out  1  data accepted this cycle when d_req=1.
- d_valid  out  1  one-cycle data response strobe.
- d_rdata  out  INSTRUCTION_SIZE  load data.
- d_err  out  1  store-to-ROM flag, valid with d_valid.
- m_pc  out  ADDR_BITS  to memory i_prog_counter.
- m_addr  out  ADDR_BITS  to memory addr.
- m_wdat  out  DATA_BITS  to memory in_dat.
- m_we, m_cs, m_mm_select  out  1 each  to memory WE, CS and i_mm_select.
- m_inst, m_dat  in  INSTRUCTION_SIZE  from memory o_inst and o_dat.
- m_error  in  1  from memory ERROR.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE and CAPTURE; the FSM SHALL reset to IDLE.
REQ-007 f_ready and d_ready SHALL be combinational, and only in IDLE.
REQ-008 Neither ready SHALL assert outside IDLE.
REQ-009 In IDLE with only one request pending, that request SHALL be granted.
REQ-010 In IDLE with both requests pending, data SHALL win unless starve_cnt==2, in which case fetch SHALL win.
REQ-011 starve_cnt (2 bits) SHALL increment, saturating at 2, on each data grant while f_req=1.
REQ-012 starve_cnt SHALL clear on any fetch grant.
REQ-013 On the grant edge E0, the block SHALL register the memory controls and enter ISSUE:
- fetch: m_cs=1, m_pc=f_pc.
- load: m_cs=0, m_we=0, m_mm_select=1, m_addr=d_addr.
- store: m_cs=0, m_we=1, m_mm_select=0, m_addr=d_addr, m_wdat=d_wdata.
REQ-014 ISSUE SHALL last one cycle, and the memory SHALL sample the controls at E1.
REQ-015 At E1 the FSM SHALL enter CAPTURE and SHALL return m_cs, m_we and m_mm_select to 0.
REQ-016 At E2 the block SHALL register m_inst into f_inst (fetch) or m_dat into d_rdata (load).
REQ-017 At E2 the block SHALL pulse the matching valid high for exactly one cycle and return to IDLE.
REQ-018 Response latency SHALL be exactly 2 cycles from the grant edge, and throughput SHALL be at most one transaction per 3 cycles.
REQ-019 For a store, d_valid SHALL pulse at E2 with d_err=m_error sampled at E2.
REQ-020 For a store, d_rdata SHALL hold its previous value.
REQ-021 For loads, d_err SHALL be 0.
REQ-022 f_inst and d_rdata SHALL hold their values between responses.
REQ-023 Requests SHALL be sampled only at the grant edge, and later changes to them SHALL have no effect.
REQ-024 Addresses SHALL pass through unmodified, with no wrap or range check in the block; ROM protection is reported via m_error only.

Reset
REQ-025 While RESET=1, independent of CLK, the block SHALL drive every output to 0 and force the FSM to IDLE.
REQ-026 While RESET=1, starve_cnt SHALL be 0.
REQ-027 Assertion of RESET mid-transaction SHALL abandon the transaction with no valid pulse.
REQ-028 The first grant SHALL be possible in the first cycle after RESET deasserts.

Verification
REQ-029 Fetch alone, f_pc=0x05, m_inst=0xA5A5 at E2 -> f_ready=1 at E0, m_cs=1 with m_pc=0x05 during ISSUE, f_valid=1 and f_inst=0xA5A5 one cycle after E2.
REQ-030 Load alone, d_addr=0x90, m_dat=0x1234 -> m_mm_select=1 with m_we=0 during ISSUE, d_valid=1 with d_rdata=0x1234 and d_err=0.
REQ-031 Store d_addr=0x10 (<ROM_SIZE), m_error=1 -> m_we=1 during ISSUE, d_valid=1 with d_err=1. Store d_addr=0x80 -> d_err=0.
REQ-032 f_req and d_req held high continuously -> grant order data, data, fetch, repeating, with starve_cnt 1, 2, 0.
REQ-033 RESET asserted during ISSUE of a fetch -> outputs 0 immediately, no f_valid, and a new grant in the first cycle after release.
